// File: rtl/ucie_csr_pkg.sv
// Shared definitions for the UCIe AHB CSR block: register offsets, version word,
// AHB response encodings and the slave FSM state type.
package ucie_csr_pkg;

  localparam logic [7:0] OFF_CTRL      = 8'h00;
  localparam logic [7:0] OFF_TXRX_MODE = 8'h04;
  localparam logic [7:0] OFF_PULSE     = 8'h08;
  localparam logic [7:0] OFF_IG_WDATA  = 8'h0C;
  localparam logic [7:0] OFF_EG_RDATA  = 8'h10;
  localparam logic [7:0] OFF_STATUS    = 8'h14;
  localparam logic [7:0] OFF_STICKY    = 8'h18;
  localparam logic [7:0] OFF_IRQ_EN    = 8'h1C;
  localparam logic [7:0] OFF_VERSION   = 8'h20;
  localparam logic [7:0] OFF_TS        = 8'h24;
  localparam logic [7:0] OFF_TS_CLR    = 8'h28;

  localparam logic [31:0] CSR_VERSION = 32'h0002_0000;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_WAIT,
    RD_DATA,
    ERR1,
    ERR2
  } state_t;

  // Word offset used for decode: only address bits [7:2] are significant.
  function automatic logic [7:0] word_off(input logic [7:0] addr);
    return {addr[7:2], 2'b00};
  endfunction

endpackage

// File: rtl/ucie_csr_sticky.sv
// Per-channel overflow sticky latches: rising-edge set, write-one-to-clear,
// with a coincident set taking priority over the clear.
module ucie_csr_sticky #(
  parameter int NUM_CH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ovf,
  input  logic [NUM_CH-1:0] w1c,
  output logic [NUM_CH-1:0] sticky
);

  logic [NUM_CH-1:0] ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q  <= '0;
      sticky <= '0;
    end else begin
      ovf_q  <= ovf;
      sticky <= (sticky & ~w1c) | (ovf & ~ovf_q);
    end
  end

endmodule

// File: rtl/ucie_ahb_csr_mc.sv
// AHB-slave CSR block for UCIe multi-channel control/status. Defining
// UCIE_CSR_TIMESTAMP_EN adds a free-running timestamp at 0x24 and its clear at 0x28.
module ucie_ahb_csr_mc
  import ucie_csr_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int NUM_CH = 2
) (
  input  logic                i_hclk,
  input  logic                i_hreset,
  input  logic [AWIDTH-1:0]   i_haddr,
  input  logic                i_hwrite,
  input  logic                i_hsel,
  input  logic [DWIDTH-1:0]   i_hwdata,
  input  logic [1:0]          i_htrans,
  input  logic [2:0]          i_hsize,
  input  logic [2:0]          i_hburst,
  input  logic                i_hreadyin,
  output logic                o_hready,
  output logic [DWIDTH-1:0]   o_hrdata,
  output logic [1:0]          o_hresp,
  output logic [2*NUM_CH-1:0] o_txrx_mode,
  output logic [NUM_CH-1:0]   o_ch_en,
  output logic [NUM_CH-1:0]   o_rxfifo_clr,
  output logic [31:0]         o_ig_wdata,
  output logic                o_ig_wdata_upd,
  input  logic [31:0]         i_eg_rdata,
  output logic                o_eg_rdata_upd,
  input  logic [4*NUM_CH-1:0] i_ch_status,
  output logic                o_irq
);

  state_t              state, state_n;
  logic [7:0]          off, addr_q;
  logic                ready_st, accept;
  logic                mapped, readable, writable, dec_err;
  logic [NUM_CH-1:0]   ch_en, irq_en, rxfifo_clr, sticky, w1c, ovf;
  logic [2*NUM_CH-1:0] txrx_mode;
  logic [31:0]         ig_wdata, rdata, rd_mux;
  logic                ig_upd, eg_upd, irq;
  logic                unused_bits;

  assign unused_bits = ^{i_haddr, i_hburst, i_htrans[0]};

  assign off      = word_off(i_haddr[7:0]);
  assign ready_st = (state != RD_WAIT) && (state != ERR1);
  assign accept   = ready_st & i_hsel & i_hreadyin & i_htrans[1];

  // Address-phase decode: errors are resolved before any state is touched.
  always_comb begin
    mapped   = 1'b1;
    readable = 1'b1;
    writable = 1'b1;
    case (off)
      OFF_CTRL, OFF_TXRX_MODE, OFF_IG_WDATA, OFF_STICKY, OFF_IRQ_EN: ;
      OFF_PULSE: readable = 1'b0;
      OFF_EG_RDATA, OFF_STATUS, OFF_VERSION: writable = 1'b0;
`ifdef UCIE_CSR_TIMESTAMP_EN
      OFF_TS:     writable = 1'b0;
      OFF_TS_CLR: readable = 1'b0;
`endif
      default: mapped = 1'b0;
    endcase
    dec_err = !mapped || (i_hsize != 3'b010) || (i_hwrite ? !writable : !readable);
  end

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n  = state;
    o_hready = 1'b1;
    o_hresp  = HRESP_OKAY;
    case (state)
      RD_WAIT: begin
        state_n  = RD_DATA;
        o_hready = 1'b0;
      end
      ERR1: begin
        state_n  = ERR2;
        o_hready = 1'b0;
        o_hresp  = HRESP_ERROR;
      end
      default: begin
        if (state == ERR2) o_hresp = HRESP_ERROR;
        if (accept)        state_n = dec_err ? ERR1 : (i_hwrite ? WRITE : RD_WAIT);
        else               state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset)    addr_q <= '0;
    else if (accept) addr_q <= off;
  end

  always_comb begin
    ovf = '0;
    for (int c = 0; c < NUM_CH; c++) ovf[c] = i_ch_status[4*c+3];
  end

  assign w1c = (state == WRITE && addr_q == OFF_STICKY) ? i_hwdata[NUM_CH-1:0] : '0;

  ucie_csr_sticky #(.NUM_CH(NUM_CH)) u_sticky (
    .clk    (i_hclk),
    .rst    (i_hreset),
    .ovf    (ovf),
    .w1c    (w1c),
    .sticky (sticky)
  );

`ifdef UCIE_CSR_TIMESTAMP_EN
  logic [31:0] ts;

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset)
      ts <= '0;
    else if (state == WRITE && addr_q == OFF_TS_CLR && i_hwdata[0])
      ts <= '0;
    else
      ts <= ts + 32'd1;
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (addr_q)
      OFF_CTRL:      rd_mux = 32'(ch_en);
      OFF_TXRX_MODE: rd_mux = 32'(txrx_mode);
      OFF_IG_WDATA:  rd_mux = ig_wdata;
      OFF_EG_RDATA:  rd_mux = i_eg_rdata;
      OFF_STATUS:    rd_mux = 32'(i_ch_status);
      OFF_STICKY:    rd_mux = 32'(sticky);
      OFF_IRQ_EN:    rd_mux = 32'(irq_en);
      OFF_VERSION:   rd_mux = CSR_VERSION;
`ifdef UCIE_CSR_TIMESTAMP_EN
      OFF_TS:        rd_mux = ts;
`endif
      default:       rd_mux = '0;
    endcase
  end

  // Writes commit on the data-phase edge; pulses appear the following cycle.
  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      ch_en      <= '0;
      txrx_mode  <= '0;
      irq_en     <= '0;
      rxfifo_clr <= '0;
      ig_wdata   <= '0;
      ig_upd     <= 1'b0;
      eg_upd     <= 1'b0;
      rdata      <= '0;
      irq        <= 1'b0;
    end else begin
      rxfifo_clr <= '0;
      ig_upd     <= 1'b0;
      eg_upd     <= 1'b0;
      irq        <= |(sticky & irq_en);
      if (state == WRITE) begin
        case (addr_q)
          OFF_CTRL:      ch_en      <= i_hwdata[NUM_CH-1:0];
          OFF_TXRX_MODE: txrx_mode  <= i_hwdata[2*NUM_CH-1:0];
          OFF_PULSE:     rxfifo_clr <= i_hwdata[NUM_CH-1:0];
          OFF_IG_WDATA: begin
            ig_wdata <= i_hwdata[31:0];
            ig_upd   <= 1'b1;
          end
          OFF_IRQ_EN:    irq_en     <= i_hwdata[NUM_CH-1:0];
          default: ;
        endcase
      end
      if (state == RD_WAIT) begin
        rdata  <= rd_mux;
        eg_upd <= (addr_q == OFF_EG_RDATA);
      end
    end
  end

  assign o_hrdata       = DWIDTH'(rdata);
  assign o_ch_en        = ch_en;
  assign o_txrx_mode    = txrx_mode;
  assign o_rxfifo_clr   = rxfifo_clr;
  assign o_ig_wdata     = ig_wdata;
  assign o_ig_wdata_upd = ig_upd;
  assign o_eg_rdata_upd = eg_upd;
  assign o_irq          = irq;

endmodule

// File: tb/tb_ucie_ahb_csr_mc.sv
// Self-checking bench for ucie_ahb_csr_mc: directed scenarios followed by random
// register traffic compared against a register-level model of the CSR map.
module tb_ucie_ahb_csr_mc;

  localparam int NUM_CH = 2;

  logic        clk, rst;
  logic [31:0] haddr, hwdata, hrdata, ig_wdata, eg_rdata;
  logic        hwrite, hsel, hreadyin, hready, ig_upd, eg_upd, irq;
  logic [1:0]  htrans, hresp, ch_en, rxfifo_clr;
  logic [2:0]  hsize, hburst;
  logic [3:0]  txrx_mode;
  logic [7:0]  ch_status;

  assign hreadyin = hready;

  ucie_ahb_csr_mc #(.AWIDTH(32), .DWIDTH(32), .NUM_CH(NUM_CH)) dut (
    .i_hclk(clk), .i_hreset(rst), .i_haddr(haddr), .i_hwrite(hwrite), .i_hsel(hsel),
    .i_hwdata(hwdata), .i_htrans(htrans), .i_hsize(hsize), .i_hburst(hburst),
    .i_hreadyin(hreadyin), .o_hready(hready), .o_hrdata(hrdata), .o_hresp(hresp),
    .o_txrx_mode(txrx_mode), .o_ch_en(ch_en), .o_rxfifo_clr(rxfifo_clr),
    .o_ig_wdata(ig_wdata), .o_ig_wdata_upd(ig_upd), .i_eg_rdata(eg_rdata),
    .o_eg_rdata_upd(eg_upd), .i_ch_status(ch_status), .o_irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int         clr_cycles = 0, ig_pulses = 0, eg_pulses = 0;
  logic [1:0] last_clr = 2'b00;

  always @(negedge clk) begin
    if (rxfifo_clr != 2'b00) begin
      clr_cycles++;
      last_clr = rxfifo_clr;
    end
    if (ig_upd) ig_pulses++;
    if (eg_upd) eg_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete transfer starting at a negedge; returns one idle cycle after completion.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input logic chk_rd, input logic [31:0] exp_rd,
                      input logic exp_er, input string tag);
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    if (exp_er) begin
      check({tag, "_err1_rdy"}, 32'(hready), 32'd0);
      check({tag, "_err1_resp"}, 32'(hresp), 32'd1);
      @(negedge clk);
      check({tag, "_err2_rdy"}, 32'(hready), 32'd1);
      check({tag, "_err2_resp"}, 32'(hresp), 32'd1);
    end else if (wr) begin
      check({tag, "_wr_rdy"}, 32'(hready), 32'd1);
      check({tag, "_wr_resp"}, 32'(hresp), 32'd0);
    end else begin
      check({tag, "_rd_wait"}, 32'(hready), 32'd0);
      @(negedge clk);
      check({tag, "_rd_rdy"}, 32'(hready), 32'd1);
      check({tag, "_rd_resp"}, 32'(hresp), 32'd0);
      if (chk_rd) check({tag, "_rd_data"}, hrdata, exp_rd);
    end
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d, input string tag);
    xfer(1'b1, a, 3'd2, d, 1'b0, 32'd0, 1'b0, tag);
  endtask

  task automatic rd_reg(input logic [31:0] a, input logic [31:0] e, input string tag);
    xfer(1'b0, a, 3'd2, 32'd0, 1'b1, e, 1'b0, tag);
  endtask

  // Register-map model.
  logic [1:0]  m_ch_en, m_irq_en, m_sticky;
  logic [3:0]  m_mode;
  logic [31:0] m_ig;
  logic [7:0]  m_status;

  function automatic logic exp_err(input logic wr, input logic [7:0] a, input logic [2:0] sz);
    if (sz != 3'd2) return 1'b1;
    case (a)
      8'h00, 8'h04, 8'h0C, 8'h18, 8'h1C: return 1'b0;
      8'h08:                             return !wr;
      8'h10, 8'h14, 8'h20:               return wr;
`ifdef UCIE_CSR_TIMESTAMP_EN
      8'h24:                             return wr;
      8'h28:                             return !wr;
`endif
      default:                           return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] exp_read(input logic [7:0] a);
    case (a)
      8'h00:   return {30'd0, m_ch_en};
      8'h04:   return {28'd0, m_mode};
      8'h0C:   return m_ig;
      8'h10:   return eg_rdata;
      8'h14:   return {24'd0, m_status};
      8'h18:   return {30'd0, m_sticky};
      8'h1C:   return {30'd0, m_irq_en};
      8'h20:   return 32'h0002_0000;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [1:0] ovf_of(input logic [7:0] s);
    return {s[7], s[3]};
  endfunction

  logic [7:0] addr_tab [13] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18,
                                8'h1C, 8'h20, 8'h24, 8'h28, 8'h40, 8'h3C};

  initial begin
    int c0, ig0, eg0, exp_clr, exp_ig, exp_eg;
    rst = 1'b1; hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hwdata = '0;
    hsize = 3'd2; hburst = 3'd0; eg_rdata = 32'h1234_5678; ch_status = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_hready", 32'(hready), 32'd1);
    check("rst_hresp", 32'(hresp), 32'd0);
    check("rst_ch_en", 32'(ch_en), 32'd0);
    check("rst_mode", 32'(txrx_mode), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ig", ig_wdata, 32'd0);
    rd_reg(32'h20, 32'h0002_0000, "version");

    // Mode register write/readback.
    wr_reg(32'h04, 32'h9, "mode_wr");
    check("mode_out", 32'(txrx_mode), 32'h9);
    rd_reg(32'h04, 32'h9, "mode_rd");

    // Self-clearing pulse register.
    c0 = clr_cycles;
    wr_reg(32'h08, 32'h2, "pulse_wr");
    repeat (2) @(negedge clk);
    check("pulse_cycles", 32'(clr_cycles - c0), 32'd1);
    check("pulse_val", 32'(last_clr), 32'h2);
    xfer(1'b0, 32'h08, 3'd2, 32'd0, 1'b0, 32'd0, 1'b1, "pulse_rd");

    // Sticky overflow, interrupt latency, set-beats-clear.
    wr_reg(32'h1C, 32'h2, "irqen_wr");
    ch_status = 8'h80;
    @(negedge clk);
    check("irq_lat0", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_lat1", 32'(irq), 32'd1);
    rd_reg(32'h18, 32'h2, "sticky_set");
    ch_status = 8'h00;
    repeat (2) @(negedge clk);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h18; hwrite = 1'b1; hsize = 3'd2;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h2; ch_status = 8'h80;
    @(negedge clk);
    rd_reg(32'h18, 32'h2, "sticky_setwins");
    check("irq_held", 32'(irq), 32'd1);
    wr_reg(32'h18, 32'h2, "sticky_w1c");
    rd_reg(32'h18, 32'h0, "sticky_clr");
    check("irq_clr", 32'(irq), 32'd0);
    ch_status = 8'h00;
    repeat (2) @(negedge clk);

    // Error responses leave CTRL untouched.
    wr_reg(32'h00, 32'h3, "ctrl_wr");
    check("ctrl_out", 32'(ch_en), 32'h3);
    xfer(1'b0, 32'h40, 3'd2, 32'd0, 1'b0, 32'd0, 1'b1, "unmap_rd");
    xfer(1'b1, 32'h00, 3'd0, 32'd0, 1'b0, 32'd0, 1'b1, "byte_wr");
    check("ctrl_kept", 32'(ch_en), 32'h3);
    rd_reg(32'h00, 32'h3, "ctrl_rd");
    xfer(1'b1, 32'h14, 3'd2, 32'hFF, 1'b0, 32'd0, 1'b1, "ro_wr");

    // Back-to-back ingress write then egress read.
    ig0 = ig_pulses; eg0 = eg_pulses; eg_rdata = 32'hCAFE_F00D;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0C; hwrite = 1'b1; hsize = 3'd2;
    @(negedge clk);
    check("b2b_wr_rdy", 32'(hready), 32'd1);
    hwdata = 32'hA5A5_A5A5; haddr = 32'h10; hwrite = 1'b0;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00;
    check("b2b_rd_wait", 32'(hready), 32'd0);
    @(negedge clk);
    check("b2b_rd_rdy", 32'(hready), 32'd1);
    check("b2b_rd_data", hrdata, 32'hCAFE_F00D);
    repeat (2) @(negedge clk);
    check("b2b_ig_pulses", 32'(ig_pulses - ig0), 32'd1);
    check("b2b_eg_pulses", 32'(eg_pulses - eg0), 32'd1);
    check("b2b_ig_data", ig_wdata, 32'hA5A5_A5A5);

    // Reset while a read is waiting.
    eg0 = eg_pulses;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b0; hsize = 3'd2;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00;
    check("mid_wait", 32'(hready), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_hready", 32'(hready), 32'd1);
    check("mid_rst_hresp", 32'(hresp), 32'd0);
    check("mid_rst_ch_en", 32'(ch_en), 32'd0);
    check("mid_rst_mode", 32'(txrx_mode), 32'd0);
    check("mid_rst_ig", ig_wdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_eg_pulses", 32'(eg_pulses - eg0), 32'd0);
    rd_reg(32'h1C, 32'h0, "mid_rst_irqen");
    rd_reg(32'h0C, 32'h0, "mid_rst_igreg");

    // Randomized traffic against the register model.
    m_ch_en = '0; m_irq_en = '0; m_sticky = '0; m_mode = '0; m_ig = '0; m_status = '0;
    c0 = clr_cycles; ig0 = ig_pulses; eg0 = eg_pulses;
    exp_clr = 0; exp_ig = 0; exp_eg = 0;
    for (int it = 0; it < 200; it++) begin
      eg_rdata = $urandom;
      if ($urandom_range(0, 9) < 2) begin
        logic [7:0] ns;
        ns = 8'($urandom);
        ch_status = ns;
        repeat (2) @(negedge clk);
        m_sticky = m_sticky | (ovf_of(ns) & ~ovf_of(m_status));
        m_status = ns;
      end else begin
        logic [7:0]  a;
        logic [31:0] hv, wd;
        logic [2:0]  sz;
        logic        wr, er;
        a  = addr_tab[$urandom_range(0, 12)];
        hv = ($urandom & 32'hFFFF_FF00) | 32'(a) | 32'($urandom_range(0, 3));
        sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
        wr = 1'($urandom_range(0, 1));
        wd = $urandom;
        er = exp_err(wr, a, sz);
        xfer(wr, hv, sz, wd, (a != 8'h24), exp_read(a), er, "rnd");
        if (!er && wr) begin
          case (a)
            8'h00: m_ch_en  = wd[1:0];
            8'h04: m_mode   = wd[3:0];
            8'h08: if (wd[1:0] != 2'b00) exp_clr++;
            8'h0C: begin m_ig = wd; exp_ig++; end
            8'h18: m_sticky = m_sticky & ~wd[1:0];
            8'h1C: m_irq_en = wd[1:0];
            default: ;
          endcase
        end
        if (!er && !wr && a == 8'h10) exp_eg++;
        repeat (2) @(negedge clk);
      end
      check("rnd_ch_en", 32'(ch_en), 32'(m_ch_en));
      check("rnd_mode", 32'(txrx_mode), 32'(m_mode));
      check("rnd_ig", ig_wdata, m_ig);
      check("rnd_irq", 32'(irq), 32'(|(m_sticky & m_irq_en)));
    end
    check("rnd_clr_cycles", 32'(clr_cycles - c0), 32'(exp_clr));
    check("rnd_ig_pulses", 32'(ig_pulses - ig0), 32'(exp_ig));
    check("rnd_eg_pulses", 32'(eg_pulses - eg0), 32'(exp_eg));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
